// File: rtl/gf_inv_if.sv
// Request/result bundle for the GF(2^M) inverter: operand in, inverse and status out.
interface gf_inv_if #(
  parameter int M = 3
);
  logic         start;
  logic [M-1:0] A;
  logic [M-1:0] Z;
  logic         busy;
  logic         done;
  logic         zero_err;

  modport master (
    output start, A,
    input  Z, busy, done, zero_err
  );

  modport slave (
    input  start, A,
    output Z, busy, done, zero_err
  );
endinterface

// File: rtl/gf_inv.sv
// Sequential GF(2^M) inverter: Z = A^(2^M-2) by square-and-multiply on one
// bit-serial MSB-first multiplier, one multiplier step per clock.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// SQR   | res <- res*res, one bit of the multiplier per cycle
// MUL   | res <- res*a_r, one bit of the multiplier per cycle
// DONE  | result cycle; start here is accepted as a back-to-back request
module gf_inv #(
  parameter int         M = 3,
  parameter logic [M:0] P = 4'b1101
) (
  input  logic     clk,
  input  logic     reset,
  gf_inv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  localparam int            CW  = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] TOP = CW'(M - 1);

  state_t        state, state_nxt;
  logic [M-1:0]  a_r, res, acc;
  logic [M-1:0]  acc_in, acc_nxt, mul_x, mul_y;
  logic [CW-1:0] j, i;
  logic          accept, last_step, running;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = bus.start && (state == IDLE || state == DONE);
    running   = (state == SQR) || (state == MUL);
    last_step = (j == '0);
    case (state)
      IDLE: if (bus.start) state_nxt = SQR;
      SQR:  if (last_step) state_nxt = (i != '0) ? MUL : DONE;
      MUL:  if (last_step) state_nxt = SQR;
      DONE: state_nxt = bus.start ? SQR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first step of every multiply sees a cleared accumulator, so no
  // separate clear cycle is spent between multiplies.
  always_comb begin
    mul_x   = res;
    mul_y   = (state == MUL) ? a_r : res;
    acc_in  = (j == TOP) ? '0 : acc;
    acc_nxt = (acc_in << 1) ^ (acc_in[M-1] ? P[M-1:0] : '0)
              ^ (mul_y[j] ? mul_x : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r          <= '0;
      res          <= '0;
      acc          <= '0;
      i            <= '0;
      j            <= '0;
      bus.Z        <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.zero_err <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        a_r      <= bus.A;
        res      <= M'(1);
        acc      <= '0;
        i        <= TOP;
        j        <= TOP;
        bus.busy <= 1'b1;
      end else if (running) begin
        acc <= acc_nxt;
        if (last_step) begin
          res <= acc_nxt;
          j   <= TOP;
          if (state == MUL) i <= i - 1'b1;
          if (state == SQR && i == '0) begin
            bus.Z        <= acc_nxt;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            bus.zero_err <= (a_r == '0);
          end
        end else begin
          j <= j - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gf_inv.sv
// Directed bench for gf_inv (M=3, P=x^3+x^2+1) with a queued scoreboard
// checked by an independent monitor on every done pulse.
module tb_gf_inv;

  logic clk = 1'b0;
  logic reset;

  gf_inv_if #(.M(3)) bus ();

  gf_inv #(.M(3), .P(4'b1101)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [2:0] z;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [2:0] gf_mul(input logic [2:0] x, input logic [2:0] y);
    logic [4:0] p;
    logic [4:0] poly;
    p    = '0;
    poly = 5'b01101;
    for (int k = 0; k < 3; k++)
      if (y[k]) p = p ^ (5'(x) << k);
    for (int k = 4; k >= 3; k--)
      if (p[k]) p = p ^ (poly << (k - 3));
    return p[2:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: Z=%b zero_err=%b, no request outstanding", bus.Z, bus.zero_err);
      end else begin
        e = sb.pop_front();
        if (bus.Z !== e.z || bus.zero_err !== e.err) begin
          errors++;
          $display("FAIL result A=%b: got Z=%b zero_err=%b, want Z=%b zero_err=%b",
                   e.a, bus.Z, bus.zero_err, e.z, e.err);
        end
        if (e.a != 3'b000) begin
          checks++;
          if (gf_mul(bus.Z, e.a) !== 3'b001) begin
            errors++;
            $display("FAIL product A=%b: Z*A=%b, want 001", e.a, gf_mul(bus.Z, e.a));
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] ez, input logic ee,
                       input bit push, input bit b2b);
    @(negedge clk);
    bus.A     = a;
    bus.start = 1'b1;
    if (push) sb.push_back('{a: a, z: ez, err: ee});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_rise", 8'(bus.busy), 8'd1);
    if (b2b) check("done_fall", 8'(bus.done), 8'd0);
  endtask

  task automatic wait_done(input bit glitch, input logic [2:0] ga);
    int n      = 0;
    int busy_n = 1;
    bit seen   = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (glitch && n == 5) begin
        bus.start = 1'b1;
        bus.A     = ga;
      end
      if (glitch && n == 6) bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_n++;
    end
    checks++;
    if (!seen || n != 15) begin
      errors++;
      $display("FAIL latency: done after %0d edges (seen=%0b), want 15", n, seen);
    end
    if (seen) begin
      check("busy_at_done", 8'(bus.busy), 8'd0);
      check("busy_cycles", 8'(busy_n), 8'd15);
    end
  endtask

  task automatic run_op(input logic [2:0] a, input logic [2:0] ez, input logic ee,
                        input bit b2b);
    if (!b2b) repeat (2) @(posedge clk);
    issue(a, ez, ee, 1'b1, b2b);
    wait_done(1'b0, 3'b000);
  endtask

  logic [2:0] sweep_a [6] = '{3'b001, 3'b100, 3'b101, 3'b011, 3'b111, 3'b110};
  logic [2:0] sweep_z [6] = '{3'b001, 3'b011, 3'b111, 3'b100, 3'b101, 3'b010};

  initial begin
    int idle_bad;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_Z", 8'(bus.Z), 8'd0);
    check("reset_busy", 8'(bus.busy), 8'd0);
    check("reset_done", 8'(bus.done), 8'd0);
    check("reset_zero_err", 8'(bus.zero_err), 8'd0);
    idle_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy || bus.done) idle_bad++;
    end
    check("idle_20", 8'(idle_bad), 8'd0);

    run_op(3'b010, 3'b110, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) run_op(sweep_a[k], sweep_z[k], 1'b0, 1'b0);
    run_op(3'b000, 3'b000, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    issue(3'b100, 3'b011, 1'b0, 1'b1, 1'b0);
    wait_done(1'b1, 3'b111);

    run_op(3'b110, 3'b010, 1'b0, 1'b0);
    run_op(3'b101, 3'b111, 1'b0, 1'b1);
    check("b2b_Z_value", 8'(bus.Z), 8'b111);

    repeat (2) @(posedge clk);
    issue(3'b011, 3'b100, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 8'(bus.busy), 8'd0);
    check("abort_done", 8'(bus.done), 8'd0);
    check("abort_Z", 8'(bus.Z), 8'd0);
    check("abort_zero_err", 8'(bus.zero_err), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) idle_bad++;
    end
    check("abort_stays_idle", 8'(idle_bad), 8'd0);
    check("scoreboard_drained", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf_inv.md
# gf_inv

Sequential GF(2^M) field inverter and the division-side counterpart of the team's GF(2^3) multiplier. It accepts a field element A in standard polynomial basis and returns Z = A^-1 mod P, computed as A^(2^M−2) by left-to-right square-and-multiply. Each multiply runs on one internal bit-serial (MSB-first) shift-and-add multiplier. It sits beside the multiplier datapath, so that x/y is computed as x·inv(y).

## Interface
- M, default 3: field degree, legal range 2..8.
- P, default 4'b1101: irreducible polynomial x^3+x^2+1, M+1 bits with P[M]=1. Only P[M-1:0] is used in reduction.
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high; sampled on clk rising edge.
- start  input  1  request; accepted only when state is IDLE or DONE.
- A  input  M  operand; captured on the accepting edge and ignored afterwards.
- Z  output  M  result register; valid while done=1 and held until the next accept or reset.
- busy  output  1  high from the accept edge until the result edge.
- done  output  1  one-cycle pulse when Z is updated.
- zero_err  output  1  high with done when the captured A was 0; held with Z.

## Operation
- States: IDLE, SQR, MUL, DONE.
- Registers:
  - a_r: captured A.
  - res: running power, initialised to 1 on accept.
  - acc: multiplier accumulator.
  - bit counter j, counting M−1 down to 0.
  - exponent index i, counting M−1 down to 0.
- Exponent is 2^M−2, binary (M−1 ones followed by one 0).
  - For i = M−1 down to 0: run SQR (res·res).
  - If i ≥ 1, follow it with MUL (res·a_r).
  - Total 2M−1 multiplies.
- Bit-serial multiply x·y, one step per cycle, j from M−1 down to 0:
  - acc ← (acc<<1) ^ (acc[M−1] ? P[M−1:0] : 0), then ^ x if y[j].
  - acc is cleared at the start of each multiply.
  - After the j=0 step, res ← final acc.
  - SQR uses x=y=res; MUL uses x=res, y=a_r.
- Transitions:
  - IDLE / DONE → SQR on start, with i=M−1 and j=M−1.
  - SQR with j=0: → MUL if i≥1, else → DONE.
  - MUL with j=0: → SQR with i−1.
  - DONE → IDLE when start=0.
- On entering DONE: Z ← final result, done=1 for exactly one cycle, zero_err ← (a_r==0).
- A=0 yields Z=0 naturally; no special datapath is required.
- start during SQR/MUL is ignored: no queueing, no restart.
- All arithmetic is M bits wide; no carries (XOR only).

## Timing
- Reset values: Z=0, busy=0, done=0, zero_err=0, state IDLE. Internal registers are cleared.
- Reset mid-operation aborts the computation. Outputs return to reset values on the next edge, and no done is produced.
- Latency: start accepted at edge k gives done=1 and Z valid after edge k+M(2M−1). For M=3 that is k+15.
- busy is high for exactly M(2M−1) cycles per operation. It drops on the same edge that raises done.
- Back-to-back: start=1 while done=1 is accepted. busy rises on the next edge, done falls, and Z holds its old value until the new result.
- reset and start in the same cycle: reset wins.

## Test plan
- Reset held 2 cycles, then released with start=0 → Z=000, busy=0, done=0, zero_err=0; state stays idle for 20 cycles.
- Single operation A=010 (α) → done exactly 15 cycles after the accept edge, Z=110 (α^6), zero_err=0; busy high for 15 cycles.
- Sweep of all elements → Z values: 001→001, 100→011, 101→111, 011→100, 111→101, 110→010. Also check Z·A=001 with a reference multiplier.
- A=000 → Z=000 and zero_err=1, both with done after 15 cycles.
- start pulsed again, and A changed, during busy → ignored; the result still equals the inverse of the originally captured A.
- Back-to-back start during the done cycle with A=101 → second done 15 cycles later, Z=111. Reset asserted at cycle 7 of a run → busy=0, no done pulse, Z=000.
